// File: rtl/instr_pkg.sv
// Shared instruction encoding: opcodes, field types, encoding layouts, immediate formats,
// the decoded-entry struct and the immediate builder used by the decoder.
package instr_pkg;

  typedef enum logic [6:0] {
    OP_LD     = 7'b0000011,
    OP_NOP    = 7'b0001111,
    OP_ARITHI = 7'b0010011,
    OP_LDUIPC = 7'b0010111,
    OP_ST     = 7'b0100011,
    OP_ARITH  = 7'b0110011,
    OP_LDUI   = 7'b0110111,
    OP_BR     = 7'b1100011,
    OP_JALR   = 7'b1100111,
    OP_BRR    = 7'b1101011,
    OP_JAL    = 7'b1101111
  } op_t;

  typedef logic [2:0] funct3_t;
  typedef logic [4:0] reg_idx_t;

  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_U, IMM_J} imm_fmt_t;

  typedef struct packed {
    logic [6:0] funct7;
    reg_idx_t   rs2;
    reg_idx_t   rs1;
    funct3_t    funct3;
    reg_idx_t   rd;
    logic [6:0] opcode;
  } instr_r_t;

  typedef struct packed {
    logic [11:0] imm12;
    reg_idx_t    rs1;
    funct3_t     funct3;
    reg_idx_t    rd;
    logic [6:0]  opcode;
  } instr_i_t;

  typedef struct packed {
    logic [6:0] imm7;
    reg_idx_t   rs2;
    reg_idx_t   rs1;
    funct3_t    funct3;
    logic [4:0] imm5;
    logic [6:0] opcode;
  } instr_s_t;

  // Shared by LDUI/LDUIPC (upper immediate) and JAL/BR (halfword offset).
  typedef struct packed {
    logic [19:0] imm20;
    reg_idx_t    rd;
    logic [6:0]  opcode;
  } instr_u_t;

  // Immediate is kept at 32 bits sign-extended; the stage widens it to XLEN.
  typedef struct packed {
    logic [6:0]  op;
    funct3_t     funct3;
    reg_idx_t    rd;
    reg_idx_t    rs1;
    reg_idx_t    rs2;
    reg_idx_t    cond;
    logic [31:0] imm;
    logic        uses_rs1;
    logic        uses_rs2;
    logic        writes_rd;
    logic        illegal;
  } dec_t;

  function automatic logic [31:0] imm_gen(input imm_fmt_t fmt, input logic [31:0] instr);
    instr_i_t fi;
    instr_s_t fs;
    instr_u_t fu;
    fi = instr_i_t'(instr);
    fs = instr_s_t'(instr);
    fu = instr_u_t'(instr);
    case (fmt)
      IMM_I:   return {{20{fi.imm12[11]}}, fi.imm12};
      IMM_S:   return {{20{fs.imm7[6]}}, fs.imm7, fs.imm5};
      IMM_U:   return {fu.imm20, 12'b0};
      IMM_J:   return {{11{fu.imm20[19]}}, fu.imm20, 1'b0};
      default: return 32'b0;
    endcase
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational field/immediate extraction and operand-usage classification.
// Zero latency; no flow control of its own.
module instr_decode
  import instr_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);

  instr_r_t f;
  imm_fmt_t fmt;
  logic     rs1_use, rs2_use, rd_wr, bad, branch;

  assign f = instr_r_t'(instr);

  always_comb begin
    fmt     = IMM_NONE;
    rs1_use = 1'b0;
    rs2_use = 1'b0;
    rd_wr   = 1'b0;
    bad     = 1'b0;
    branch  = 1'b0;
    case (f.opcode)
      OP_ARITH:  begin rs1_use = 1'b1; rs2_use = 1'b1; rd_wr = 1'b1; end
      OP_ARITHI: begin fmt = IMM_I; rs1_use = 1'b1; rd_wr = 1'b1; end
      OP_LD: begin
        fmt = IMM_I; rs1_use = 1'b1; rd_wr = 1'b1;
        bad = (f.funct3 == 3'b011) || (f.funct3[2:1] == 2'b11);
      end
      OP_ST: begin
        fmt = IMM_S; rs1_use = 1'b1; rs2_use = 1'b1;
        bad = (f.funct3 >= 3'b011);
      end
      OP_LDUI, OP_LDUIPC: begin fmt = IMM_U; rd_wr = 1'b1; end
      OP_JAL:    begin fmt = IMM_J; rd_wr = 1'b1; end
      OP_JALR:   begin fmt = IMM_I; rs1_use = 1'b1; rd_wr = 1'b1; end
      OP_BR:     begin fmt = IMM_J; branch = 1'b1; end
      OP_BRR:    begin fmt = IMM_I; rs1_use = 1'b1; branch = 1'b1; end
      OP_NOP:    ;
      default:   bad = 1'b1;
    endcase
  end

  // Branches reuse bits [11:7] as a condition code, not a destination.
  always_comb begin
    dec           = '0;
    dec.op        = f.opcode;
    dec.funct3    = f.funct3;
    dec.rs1       = f.rs1;
    dec.rs2       = f.rs2;
    dec.rd        = branch ? 5'd0 : f.rd;
    dec.cond      = branch ? f.rd : 5'd0;
    dec.imm       = imm_gen(fmt, f);
    dec.illegal   = bad;
    dec.uses_rs1  = rs1_use & ~bad;
    dec.uses_rs2  = rs2_use & ~bad;
    dec.writes_rd = rd_wr & ~bad & (f.rd != 5'd0);
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: instruction word in, decoded entry out through a 1- or 2-entry buffer, latency 1.
// BUF_DEPTH=2 stalls on a registered full flag; BUF_DEPTH=1 forwards out_ready into in_ready.
module decode_stage
  import instr_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [6:0]      out_op,
  output logic [2:0]      out_funct3,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_cond,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_pc,
  output logic            out_uses_rs1,
  output logic            out_uses_rs2,
  output logic            out_writes_rd,
  output logic            out_illegal
);

  localparam int CW = $clog2(BUF_DEPTH + 1);

  dec_t                           dec_new;
  dec_t [BUF_DEPTH-1:0]           dec_q, dec_d;
  dec_t [BUF_DEPTH:0]             dec_x;
  logic [BUF_DEPTH-1:0][XLEN-1:0] pc_q, pc_d;
  logic [BUF_DEPTH:0][XLEN-1:0]   pc_x;
  logic [CW-1:0]                  cnt_q, cnt_d, wr_idx;
  logic                           push, pop;
  logic signed [31:0]             head_imm;

  instr_decode u_instr_decode (
    .instr (in_instr),
    .dec   (dec_new)
  );

  if (BUF_DEPTH == 2) begin : g_reg_ready
    assign in_ready = !rst && (cnt_q != CW'(BUF_DEPTH));
  end else begin : g_pass_ready
    assign in_ready = !rst && (!out_valid || out_ready);
  end

  assign out_valid = (cnt_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Slot 0 is the head; a pop shifts everything down, a push lands behind the survivors.
  always_comb begin
    dec_x  = {dec_t'('0), dec_q};
    pc_x   = {XLEN'(0), pc_q};
    wr_idx = cnt_q - CW'(pop);
    cnt_d  = cnt_q + CW'(push) - CW'(pop);
    dec_d  = dec_q;
    pc_d   = pc_q;
    for (int i = 0; i < BUF_DEPTH; i++) begin
      dec_d[i] = pop ? dec_x[i+1] : dec_x[i];
      pc_d[i]  = pop ? pc_x[i+1]  : pc_x[i];
      if (push && (wr_idx == CW'(i))) begin
        dec_d[i] = dec_new;
        pc_d[i]  = in_pc;
      end
    end
  end

  // Flush also discards any word accepted in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      cnt_q <= '0;
      dec_q <= '0;
      pc_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      dec_q <= dec_d;
      pc_q  <= pc_d;
    end
  end

  assign head_imm      = dec_q[0].imm;
  assign out_imm       = XLEN'(head_imm);
  assign out_pc        = pc_q[0];
  assign out_op        = dec_q[0].op;
  assign out_funct3    = dec_q[0].funct3;
  assign out_rd        = dec_q[0].rd;
  assign out_rs1       = dec_q[0].rs1;
  assign out_rs2       = dec_q[0].rs2;
  assign out_cond      = dec_q[0].cond;
  assign out_uses_rs1  = dec_q[0].uses_rs1;
  assign out_uses_rs2  = dec_q[0].uses_rs2;
  assign out_writes_rd = dec_q[0].writes_rd;
  assign out_illegal   = dec_q[0].illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed and randomized checks of decode_stage (XLEN=32, BUF_DEPTH=2)
// against a queue-based reference model of the decode rules.
module tb_decode_stage;

  localparam logic [6:0] LD = 7'h03, NOP = 7'h0F, ARITHI = 7'h13, LDUIPC = 7'h17,
                         ST = 7'h23, ARITH = 7'h33, LDUI = 7'h37, BR = 7'h63,
                         JALR = 7'h67, BRR = 7'h6B, JAL = 7'h6F;

  typedef struct packed {
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  cond;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        uses_rs1;
    logic        uses_rs2;
    logic        writes_rd;
    logic        illegal;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_imm, out_pc;
  logic [6:0]  out_op;
  logic [2:0]  out_funct3;
  logic [4:0]  out_rd, out_rs1, out_rs2, out_cond;
  logic        out_uses_rs1, out_uses_rs2, out_writes_rd, out_illegal;

  int   n_assert = 0;
  int   n_fail   = 0;
  ent_t q[$];

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .BUF_DEPTH(2)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .out_funct3(out_funct3), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_cond(out_cond), .out_imm(out_imm), .out_pc(out_pc),
    .out_uses_rs1(out_uses_rs1), .out_uses_rs2(out_uses_rs2),
    .out_writes_rd(out_writes_rd), .out_illegal(out_illegal)
  );

  function automatic ent_t mk(input logic [6:0] op, input logic [2:0] f3,
                              input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [4:0] cond,
                              input logic [31:0] imm, input logic [31:0] pc,
                              input logic u1, input logic u2, input logic wr,
                              input logic ill);
    return '{op: op, funct3: f3, rd: rd, rs1: rs1, rs2: rs2, cond: cond, imm: imm,
             pc: pc, uses_rs1: u1, uses_rs2: u2, writes_rd: wr, illegal: ill};
  endfunction

  // Reference decode: immediates via signed shifts and masks on the whole word.
  function automatic ent_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
    ent_t               e;
    logic [6:0]         op;
    logic [2:0]         f3;
    logic signed [31:0] sw;
    logic [31:0]        i_imm, j_imm;
    logic               br, known;
    op    = w[6:0];
    f3    = w[14:12];
    sw    = w;
    i_imm = sw >>> 20;
    j_imm = sw >>> 12;
    br    = (op == BR) || (op == BRR);
    known = op inside {LD, NOP, ARITHI, LDUIPC, ST, ARITH, LDUI, BR, JALR, BRR, JAL};
    e        = '0;
    e.op     = op;
    e.funct3 = f3;
    e.rs1    = w[19:15];
    e.rs2    = w[24:20];
    e.pc     = pc;
    if (br) e.cond = w[11:7];
    else    e.rd   = w[11:7];
    e.illegal = !known || (op == LD && f3 inside {3'd3, 3'd6, 3'd7}) || (op == ST && f3 >= 3'd3);
    if (op inside {ARITHI, LD, JALR, BRR}) e.imm = i_imm;
    else if (op == ST)                     e.imm = (i_imm & ~32'h1F) | ((w >> 7) & 32'h1F);
    else if (op inside {LDUI, LDUIPC})     e.imm = w & 32'hFFFFF000;
    else if (op inside {JAL, BR})          e.imm = j_imm << 1;
    if (!e.illegal) begin
      e.uses_rs1  = op inside {ARITH, ARITHI, LD, ST, JALR, BRR};
      e.uses_rs2  = op inside {ARITH, ST};
      e.writes_rd = (op inside {ARITH, ARITHI, LDUI, LDUIPC, LD, JAL, JALR}) && (w[11:7] != 5'd0);
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 13))
      0: w[6:0] = LD;     1: w[6:0] = NOP;   2: w[6:0] = ARITHI; 3: w[6:0] = LDUIPC;
      4: w[6:0] = ST;     5: w[6:0] = ARITH; 6: w[6:0] = LDUI;   7: w[6:0] = BR;
      8: w[6:0] = JALR;   9: w[6:0] = BRR;   10: w[6:0] = JAL;
      default: ;
    endcase
    if ($urandom_range(0, 7) == 0) w[11:7] = 5'd0;
    return w;
  endfunction

  function automatic ent_t observed();
    return '{op: out_op, funct3: out_funct3, rd: out_rd, rs1: out_rs1, rs2: out_rs2,
             cond: out_cond, imm: out_imm, pc: out_pc, uses_rs1: out_uses_rs1,
             uses_rs2: out_uses_rs2, writes_rd: out_writes_rd, illegal: out_illegal};
  endfunction

  task automatic chk1(input string tag, input logic obs_v, input logic exp_v);
    n_assert++;
    assert (obs_v === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs_v, exp_v);
    end
  endtask

  task automatic chk_ent(input string tag, input ent_t exp_e);
    ent_t o;
    o = observed();
    n_assert++;
    assert (o === exp_e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, o, exp_e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] i0, i1, i2;
  logic        do_push;

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    i0 = 32'h00100093; i1 = 32'h00208113; i2 = 32'h00310193;

    // Reset behaviour
    step();
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_in_ready", in_ready, 1'b0);
    chk_ent("rst_contents", '0);
    rst = 1'b0;
    step();
    chk1("post_rst_in_ready", in_ready, 1'b1);
    chk1("post_rst_out_valid", out_valid, 1'b0);

    // Directed decode vectors at full throughput
    out_ready = 1'b1; in_valid = 1'b1;
    in_instr = 32'h00A28293; in_pc = 32'h1000;
    step();
    chk1("addi_valid", out_valid, 1'b1);
    chk_ent("addi", mk(7'h13, 3'd0, 5'd5, 5'd5, 5'd10, 5'd0, 32'd10, 32'h1000, 1, 0, 1, 0));
    in_instr = 32'hFE612E23; in_pc = 32'h1004;
    step();
    chk_ent("sw", mk(7'h23, 3'd2, 5'd28, 5'd2, 5'd6, 5'd0, 32'hFFFFFFFC, 32'h1004, 1, 1, 0, 0));
    in_instr = 32'h123452B7; in_pc = 32'h1008;
    step();
    chk1("thru_in_ready", in_ready, 1'b1);
    chk_ent("lui", mk(7'h37, 3'd5, 5'd5, 5'd8, 5'd3, 5'd0, 32'h12345000, 32'h1008, 0, 0, 1, 0));
    in_instr = 32'h00003003; in_pc = 32'h100C;
    step();
    chk_ent("ld_illegal", mk(7'h03, 3'd3, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'h100C, 0, 0, 0, 1));
    in_valid = 1'b0;
    step();
    chk1("drain_empty", out_valid, 1'b0);

    // Backpressure: two accepted, third waits, then ordered drain
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = i0; in_pc = 32'h2000;
    step();
    chk1("bp_rdy_one", in_ready, 1'b1);
    in_instr = i1; in_pc = 32'h2004;
    step();
    chk1("bp_rdy_full", in_ready, 1'b0);
    chk_ent("bp_head0", ref_decode(i0, 32'h2000));
    in_instr = i2; in_pc = 32'h2008;
    step();
    chk1("bp_still_full", in_ready, 1'b0);
    chk_ent("bp_hold", ref_decode(i0, 32'h2000));
    out_ready = 1'b1;
    step();
    chk_ent("bp_second", ref_decode(i1, 32'h2004));
    chk1("bp_rdy_reopen", in_ready, 1'b1);
    step();
    chk_ent("bp_third", ref_decode(i2, 32'h2008));
    in_valid = 1'b0;
    step();
    chk1("bp_empty", out_valid, 1'b0);

    // Flush of a full buffer with input offered, then flush of a transferring word
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = i0; in_pc = 32'h3000; step();
    in_instr = i1; in_pc = 32'h3004; step();
    flush = 1'b1; in_instr = i2; in_pc = 32'h3008;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk1("flush_full_valid", out_valid, 1'b0);
    step();
    chk1("flush_no_emit", out_valid, 1'b0);
    in_valid = 1'b1; in_instr = i0; in_pc = 32'h3100; step();
    flush = 1'b1; in_instr = i1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk1("flush_drop_in", out_valid, 1'b0);
    chk1("flush_rdy", in_ready, 1'b1);

    // Reset mid-stream
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = i0; in_pc = 32'h4000; step();
    in_instr = i1; in_pc = 32'h4004; step();
    rst = 1'b1;
    step();
    chk1("midrst_valid", out_valid, 1'b0);
    chk1("midrst_rdy", in_ready, 1'b0);
    chk_ent("midrst_zero", '0);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk1("midrst_no_emit", out_valid, 1'b0);

    // Randomized traffic against the queue model
    q.delete();
    for (int cyc = 0; cyc < 800; cyc++) begin
      chk1("rnd_out_valid", out_valid, q.size() != 0);
      chk1("rnd_in_ready", in_ready, !rst && (q.size() < 2));
      if (q.size() != 0) chk_ent("rnd_entry", q[0]);
      rst       = ($urandom_range(0, 99) < 2);
      flush     = !rst && ($urandom_range(0, 99) < 5);
      in_valid  = ($urandom_range(0, 99) < 70);
      out_ready = ($urandom_range(0, 99) < 60);
      in_instr  = rand_instr();
      in_pc     = $urandom;
      if (rst || flush) begin
        q.delete();
      end else begin
        do_push = in_valid && (q.size() < 2);
        if (q.size() != 0 && out_ready) void'(q.pop_front());
        if (do_push) q.push_back(ref_decode(in_instr, in_pc));
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath/immediate/PC width; SHALL be >= 32.
REQ-002 Parameter BUF_DEPTH, default 2, output buffer entries; SHALL be 1 or 2.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  in_instr/in_pc valid.
REQ-006 in_ready  output  1  stage accepts input this cycle.
REQ-007 in_instr  input  32  raw instruction word.
REQ-008 in_pc  input  XLEN  instruction address.
REQ-009 flush  input  1  discard all buffered and incoming instructions.
REQ-010 out_valid  output  1  decoded entry present.
REQ-011 out_ready  input  1  consumer accepts entry.
REQ-012 out_op  output  7  opcode, op_t.
REQ-013 out_funct3 / out_rd / out_rs1 / out_rs2 / out_cond  output  3/5/5/5/5  raw fields.
REQ-014 out_imm  output  XLEN  sign-extended immediate.
REQ-015 out_pc  output  XLEN  in_pc of the entry.
REQ-016 out_uses_rs1 / out_uses_rs2 / out_writes_rd  output  1 each  operand usage flags.
REQ-017 out_illegal  output  1  undecodable instruction.

Function
REQ-018 Transfer SHALL occur on valid&ready; entry SHALL appear at outputs one cycle after input transfer (latency 1), in order.
REQ-019 While out_valid & !out_ready, all out_* SHALL hold stable.
REQ-020 BUF_DEPTH=2: in_ready SHALL be registered (not full), with no combinational path from out_ready; full throughput SHALL be sustained.
REQ-021 BUF_DEPTH=1: in_ready SHALL be !out_valid | out_ready.
REQ-022 Immediate: ARITHI/LD/JALR/BRR sext(imm12); ST sext({imm7,imm5}); LDUI/LDUIPC sext({imm20,12'b0}); JAL/BR sext({imm20,1'b0}); ARITH/NOP 0.
REQ-023 uses_rs1: ARITH, ARITHI, LD, ST, JALR, BRR; uses_rs2: ARITH, ST.
REQ-024 writes_rd: ARITH, ARITHI, LDUI, LDUIPC, LD, JAL, JALR, and rd != 0; BR/BRR expose bits [11:7] on out_cond only.
REQ-025 illegal: unknown opcode, LD funct3 in {011,110,111}, ST funct3 >= 011; illegal entries SHALL pass through with uses/writes flags 0.
REQ-026 flush: all entries SHALL be invalid next cycle; input transferred in the flush cycle SHALL be discarded; flush overrides simultaneous out_ready.
REQ-027 Buffer full with simultaneous push and pop SHALL keep occupancy and order.

Reset
REQ-028 In rst cycle out_valid SHALL become 0 and all buffer contents 0; in_ready SHALL be 0 during rst, 1 the cycle after.
REQ-029 rst mid-stream SHALL drop all entries without emitting them.

Structure
REQ-030 op_t, field typedefs, encoding structs, and an immediate-format enum SHALL live in the shared Instr package.
REQ-031 Combinational field/immediate extraction SHALL be one sub-module, instr_decode; buffering in decode_stage.

Verification
REQ-032 in 0x00A28293 (addi x5,x5,10) -> op 0010011, rd 5, rs1 5, imm 10, uses_rs1 1, writes_rd 1, one cycle later.
REQ-033 in 0xFE612E23 (sw x6,-4(x2)) -> imm 0xFFFFFFFC, rs1 2, rs2 6, writes_rd 0.
REQ-034 in 0x123452B7 -> imm 0x12345000, rd 5, writes_rd 1; in 0x00003003 -> illegal 1.
REQ-035 BUF_DEPTH=2, out_ready=0, offer 3 instrs -> 2 accepted, in_ready 0; release -> drained in order, third accepted.
REQ-036 Buffer full, flush with in_valid=1 -> out_valid 0 next cycle, no entries emitted.
